// File: rtl/branch_seq.sv
// Conditional-branch control sequencer: evaluates the condition flop, then
// (if taken) walks PC + sign-extended offset through Y/Z back into PC.
module branch_seq #(
    parameter logic [4:0] BR_OPCODE = 5'b10010,
    parameter int         CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      IR,
    input  logic             CON_out,
    output logic             Gra,
    output logic             Rout,
    output logic             CONin,
    output logic             PCout,
    output logic             Yin,
    output logic             Cout,
    output logic             ADD,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCin,
    output logic [1:0]       cond,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             err,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [2:0] {
        IDLE, EVAL, SETTLE, DECIDE, PCY, ADDZ, LOAD, FIN
    } stateT;

    // Strobe order: {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin}
    localparam logic [9:0] STROBE_EVAL = 10'b1110000000;
    localparam logic [9:0] STROBE_PCY  = 10'b0001100000;
    localparam logic [9:0] STROBE_ADDZ = 10'b0000011100;
    localparam logic [9:0] STROBE_LOAD = 10'b0000000011;

    stateT            state, stateNext;
    logic             flag, flagNext;
    logic [9:0]       strobes, strobeNext;
    logic [1:0]       condNext;
    logic             busyNext, doneNext, takenNext, errNext;
    logic [CNT_W-1:0] cntNext;

    // Ra, the immediate and spare bits are consumed by the datapath, not here.
    logic unusedIrBits;
    assign unusedIrBits = ^{IR[26:21], IR[18:0]};

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin} = strobes;

    always_comb begin
        stateNext  = state;
        flagNext   = flag;
        condNext   = cond;
        takenNext  = taken;
        cntNext    = taken_cnt;
        strobeNext = '0;
        errNext    = 1'b0;
        doneNext   = 1'b0;
        busyNext   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (IR[31:27] == BR_OPCODE) begin
                        stateNext = EVAL;
                        condNext  = IR[20:19];
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            EVAL:    stateNext = SETTLE;
            SETTLE:  stateNext = DECIDE;
            DECIDE: begin
                flagNext  = CON_out;
                stateNext = CON_out ? PCY : FIN;
            end
            PCY:     stateNext = ADDZ;
            ADDZ:    stateNext = LOAD;
            LOAD:    stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // Outputs are decoded from the upcoming state so they come out of flops.
        case (stateNext)
            EVAL: strobeNext = STROBE_EVAL;
            PCY:  strobeNext = STROBE_PCY;
            ADDZ: strobeNext = STROBE_ADDZ;
            LOAD: strobeNext = STROBE_LOAD;
            FIN: begin
                doneNext  = 1'b1;
                takenNext = flagNext;
                if (flagNext) cntNext = satInc(taken_cnt);
            end
            default: strobeNext = '0;
        endcase
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            flag      <= 1'b0;
            strobes   <= '0;
            cond      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            taken     <= 1'b0;
            err       <= 1'b0;
            taken_cnt <= '0;
        end else begin
            state     <= stateNext;
            flag      <= flagNext;
            strobes   <= strobeNext;
            cond      <= condNext;
            busy      <= busyNext;
            done      <= doneNext;
            taken     <= takenNext;
            err       <= errNext;
            taken_cnt <= cntNext;
        end
    end

endmodule

// File: tb/tb_branch_seq.sv
// Bench for branch_seq: table of branches with a scoreboard of completions,
// plus directed error, reset-priority and mid-branch reset sequences.
module tb_branch_seq;

    localparam logic [4:0] BR = 5'b10010;

    // Packed order: {Gra,Rout,CONin,PCout,Yin,Cout,ADD,Zin,Zlowout,PCin,busy,done,err}
    localparam logic [12:0] V_EVAL = 13'b1110000000_000;
    localparam logic [12:0] V_PCY  = 13'b0001100000_000;
    localparam logic [12:0] V_ADDZ = 13'b0000011100_000;
    localparam logic [12:0] V_LOAD = 13'b0000000011_000;
    localparam logic [12:0] V_BUSY = 13'b0000000000_100;
    localparam logic [12:0] V_DONE = 13'b0000000000_010;
    localparam logic [12:0] V_ERR  = 13'b0000000000_001;

    typedef struct {
        logic [31:0] ir;
        logic        conVal;
        logic        hold;
        logic        expTaken;
        int          expLat;
        logic [1:0]  expCond;
    } vec_t;

    typedef struct {
        logic        taken;
        int          lat;
        logic [1:0]  cond;
        logic [15:0] cnt16;
        logic [1:0]  cnt2;
    } exp_t;

    logic clock = 1'b0;
    logic reset, start, CON_out;
    logic [31:0] IR;

    logic Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin;
    logic busy, done, taken, err;
    logic [1:0] cond;
    logic [15:0] taken_cnt;

    logic gra2, rout2, conin2, pcout2, yin2, cout2, add2, zin2, zlowout2, pcin2;
    logic busy2, done2, taken2, err2;
    logic [1:0] cond2, cnt2;

    logic [12:0] vec1, vec2;
    assign vec1 = {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, busy, done, err};
    assign vec2 = {gra2, rout2, conin2, pcout2, yin2, cout2, add2, zin2, zlowout2, pcin2, busy2, done2, err2};

    int compared = 0;
    int mismatched = 0;
    exp_t sb[$];
    logic [15:0] expCnt16 = '0;
    logic [1:0]  expCnt2 = '0;
    logic        lastTaken = 1'b0;
    logic [1:0]  lastCond = 2'b00;
    vec_t vecs[6];

    always #5 clock = ~clock;

    branch_seq dut (
        .clock(clock), .reset(reset), .start(start), .IR(IR), .CON_out(CON_out),
        .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin),
        .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
        .cond(cond), .busy(busy), .done(done), .taken(taken), .err(err),
        .taken_cnt(taken_cnt)
    );

    branch_seq #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .IR(IR), .CON_out(CON_out),
        .Gra(gra2), .Rout(rout2), .CONin(conin2), .PCout(pcout2), .Yin(yin2),
        .Cout(cout2), .ADD(add2), .Zin(zin2), .Zlowout(zlowout2), .PCin(pcin2),
        .cond(cond2), .busy(busy2), .done(done2), .taken(taken2), .err(err2),
        .taken_cnt(cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra, input logic [1:0] c2);
        return {op, ra, 2'b01, c2, 19'h2A5C3};
    endfunction

    function automatic logic [12:0] expVec(input logic tk, input int k);
        logic [12:0] r;
        r = '0;
        if (tk) begin
            case (k)
                1:       r = V_EVAL | V_BUSY;
                2, 3:    r = V_BUSY;
                4:       r = V_PCY | V_BUSY;
                5:       r = V_ADDZ | V_BUSY;
                6:       r = V_LOAD | V_BUSY;
                7:       r = V_BUSY | V_DONE;
                default: r = '0;
            endcase
        end else begin
            case (k)
                1:       r = V_EVAL | V_BUSY;
                2, 3:    r = V_BUSY;
                4:       r = V_BUSY | V_DONE;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Caller is positioned just after a falling edge with the DUT idle.
    task automatic runBranch(input vec_t v);
        exp_t e, got;
        bit seen;
        if (v.expTaken) begin
            if (expCnt16 != 16'hFFFF) expCnt16 = expCnt16 + 16'd1;
            if (expCnt2 != 2'b11) expCnt2 = expCnt2 + 2'd1;
        end
        e = '{v.expTaken, v.expLat, v.expCond, expCnt16, expCnt2};
        start = 1'b1;
        IR = v.ir;
        CON_out = ~v.conVal;
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge clock);
            check("seq_strobes", 32'({vec1, vec2}), 32'({expVec(v.expTaken, k), expVec(v.expTaken, k)}));
            check("seq_taken_cond", 32'({taken, cond, taken2, cond2}),
                  (k < v.expLat) ? 32'({lastTaken, v.expCond, lastTaken, v.expCond})
                                 : 32'({v.expTaken, v.expCond, v.expTaken, v.expCond}));
            if (done && sb.size() > 0) begin
                got = sb.pop_front();
                seen = 1'b1;
                check("latency", k, got.lat);
                check("done_taken", 32'(taken), 32'(got.taken));
                check("done_cond", 32'(cond), 32'(got.cond));
                check("taken_cnt", 32'({taken_cnt, cnt2}), 32'({got.cnt16, got.cnt2}));
            end
            start = v.hold;
            IR = $urandom();
            CON_out = (k == 3) ? v.conVal : ~v.conVal;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done expected done at cycle %0d", v.expLat);
        end
        @(negedge clock);
        check("idle_after", 32'({vec1, vec2}), 32'(0));
        start = 1'b0;
        CON_out = 1'b0;
        lastTaken = v.expTaken;
        lastCond = v.expCond;
    endtask

    initial begin
        int doneSeen;
        reset = 1'b1;
        start = 1'b0;
        IR = '0;
        CON_out = 1'b0;

        vecs[0] = '{mkIr(BR, 4'd3,  2'b00), 1'b1, 1'b0, 1'b1, 7, 2'b00};
        vecs[1] = '{mkIr(BR, 4'd5,  2'b01), 1'b0, 1'b0, 1'b0, 4, 2'b01};
        vecs[2] = '{mkIr(BR, 4'd9,  2'b10), 1'b1, 1'b1, 1'b1, 7, 2'b10};
        vecs[3] = '{mkIr(BR, 4'd12, 2'b11), 1'b0, 1'b1, 1'b0, 4, 2'b11};
        vecs[4] = '{mkIr(BR, 4'd1,  2'b11), 1'b1, 1'b0, 1'b1, 7, 2'b11};
        vecs[5] = '{mkIr(BR, 4'd15, 2'b10), 1'b1, 1'b0, 1'b1, 7, 2'b10};

        repeat (2) @(negedge clock);
        check("reset_strobes", 32'({vec1, vec2}), 32'(0));
        check("reset_regs", 32'({taken, cond, taken_cnt, taken2, cond2, cnt2}), 32'(0));
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 6; i++) runBranch(vecs[i]);

        // Non-branch opcode: single err pulse, nothing else moves.
        start = 1'b1;
        IR = {5'b00011, 27'h5A5A5A5};
        @(negedge clock);
        check("err_pulse", 32'({vec1, vec2}), 32'({V_ERR, V_ERR}));
        check("err_hold", 32'({taken, cond, taken2, cond2}), 32'({lastTaken, lastCond, lastTaken, lastCond}));
        start = 1'b0;
        @(negedge clock);
        check("err_once", 32'({vec1, vec2}), 32'(0));

        // Reset wins over a valid start in the same cycle and clears the counters.
        reset = 1'b1;
        start = 1'b1;
        IR = mkIr(BR, 4'd2, 2'b01);
        @(negedge clock);
        check("rst_prio_strobes", 32'({vec1, vec2}), 32'(0));
        check("rst_prio_regs", 32'({taken, cond, taken_cnt, taken2, cond2, cnt2}), 32'(0));
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("rst_prio_idle", 32'({vec1, vec2}), 32'(0));

        // Reset during ADDZ aborts the branch with no completion.
        start = 1'b1;
        IR = mkIr(BR, 4'd7, 2'b11);
        CON_out = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 5) check("addz_strobes", 32'({vec1, vec2}), 32'({V_ADDZ | V_BUSY, V_ADDZ | V_BUSY}));
            start = 1'b0;
            CON_out = (k == 3);
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort_strobes", 32'({vec1, vec2}), 32'(0));
        check("abort_regs", 32'({taken, cond, taken_cnt, taken2, cond2, cnt2}), 32'(0));
        reset = 1'b0;
        CON_out = 1'b0;
        doneSeen = 0;
        repeat (10) begin
            @(negedge clock);
            if (done || done2 || busy || busy2) doneSeen++;
        end
        check("abort_no_done", doneSeen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
